execute_stage: RTL and testbench

- EX stage of the 5-stage pipeline. Sits directly upstream of the memory stage and contains the EX/MEM pipeline register, so every output is registered.
- Performs single-cycle ALU ops.
- Runs an iterative 32-cycle shift-add multiply and stalls decode while it runs.
- Passes the control fields needed by the memory and writeback stages.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/seq_multiplier.sv | 78 +++++++
 rtl/execute_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_execute_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, ALU opcodes and the EX-stage FSM states.
package pipe_pkg;

    localparam int DATA_W    = 32;
    localparam int PC_W      = 13;
    localparam int REG_W     = 3;
    localparam int ALUOP_W   = 4;
    localparam int MUL_ITERS = 32;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SRA = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'd8;
    localparam logic [ALUOP_W-1:0] ALU_MUL = 4'd9;

    typedef enum logic {
        EX_IDLE = 1'b0,
        EX_MUL  = 1'b1
    } ex_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier: one partial-product step per clock, low W bits kept.
module seq_multiplier
    import pipe_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         kill_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] product_o
);

    localparam logic [5:0] LAST_ITER = 6'(MUL_ITERS - 1);

    logic [W-1:0] mcand_q, mcand_d;
    logic [W-1:0] mplier_q, mplier_d;
    logic [W-1:0] acc_q, acc_d;
    logic [5:0]   cnt_q, cnt_d;
    logic         busy_q, busy_d;
    logic [W-1:0] acc_step;

    // done is combinational so the stage can capture the final sum on the same edge it is formed
    always_comb begin
        acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        done_o    = busy_q && (cnt_q == LAST_ITER);
        product_o = acc_step;
        busy_o    = busy_q;
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (kill_i) begin
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q == LAST_ITER) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage: single-cycle ALU, 32-cycle iterative multiply with decode stall, and the EX/MEM register.
module execute_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int PC_W   = pipe_pkg::PC_W,
    parameter int REG_W  = pipe_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Valid_In,
    input  logic              flush,
    input  logic [PC_W-1:0]   PC,
    input  logic [DATA_W-1:0] OpA,
    input  logic [DATA_W-1:0] OpB,
    input  logic [DATA_W-1:0] Imm,
    input  logic              ALUSrc,
    input  logic [3:0]        ALUOp,
    input  logic              Mem_Write,
    input  logic              Mem_Read_In,
    input  logic              Reg_Write_In,
    input  logic [REG_W-1:0]  WBReg_In,
    output logic              Stall,
    output logic [PC_W-1:0]   PCOut,
    output logic [DATA_W-1:0] ALURes,
    output logic [DATA_W-1:0] WriteDataOut,
    output logic              Mem_Write_Out,
    output logic              Mem_Read_Out,
    output logic              Reg_Write_Out,
    output logic [REG_W-1:0]  WBReg_Out,
    output logic              Valid_Out
);

    function automatic logic [DATA_W-1:0] alu_eval(input logic [3:0]        op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic [DATA_W-1:0]        r;
        sa = a;
        sb = b;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLL: r = a << b[4:0];
            ALU_SRL: r = a >> b[4:0];
            ALU_SRA: r = sa >>> b[4:0];
            ALU_SLT: r = (sa < sb) ? DATA_W'(1) : '0;
            default: r = '0;  // MUL is handled by the multiplier; reserved codes yield 0
        endcase
        return r;
    endfunction

    ex_state_e state_q, state_d;

    // EX/MEM register
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              mw_q, mw_d;
    logic              mr_q, mr_d;
    logic              rw_q, rw_d;
    logic [REG_W-1:0]  wb_q, wb_d;
    logic              vld_q, vld_d;

    // Fields of the multiply in flight, held until the product is ready
    logic [PC_W-1:0]   lat_pc_q, lat_pc_d;
    logic [DATA_W-1:0] lat_wd_q, lat_wd_d;
    logic              lat_mw_q, lat_mw_d;
    logic              lat_mr_q, lat_mr_d;
    logic              lat_rw_q, lat_rw_d;
    logic [REG_W-1:0]  lat_wb_q, lat_wb_d;

    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic              mul_start;
    logic              mul_kill;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    seq_multiplier #(
        .W(DATA_W)
    ) u_mul (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (mul_start),
        .kill_i   (mul_kill),
        .a_i      (OpA),
        .b_i      (op_b),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

    always_comb begin
        op_b    = ALUSrc ? Imm : OpB;
        alu_res = alu_eval(ALUOp, OpA, op_b);
        Stall   = (state_q == EX_MUL);
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        res_d     = res_q;
        wd_d      = wd_q;
        mw_d      = mw_q;
        mr_d      = mr_q;
        rw_d      = rw_q;
        wb_d      = wb_q;
        vld_d     = vld_q;
        lat_pc_d  = lat_pc_q;
        lat_wd_d  = lat_wd_q;
        lat_mw_d  = lat_mw_q;
        lat_mr_d  = lat_mr_q;
        lat_rw_d  = lat_rw_q;
        lat_wb_d  = lat_wb_q;
        mul_start = 1'b0;
        mul_kill  = 1'b0;

        if (flush) begin
            state_d  = EX_IDLE;
            mul_kill = 1'b1;
            vld_d    = 1'b0;
            mw_d     = 1'b0;
            mr_d     = 1'b0;
            rw_d     = 1'b0;
        end else begin
            case (state_q)
                EX_IDLE: begin
                    if (Valid_In && (ALUOp == ALU_MUL)) begin
                        mul_start = 1'b1;
                        state_d   = EX_MUL;
                        lat_pc_d  = PC;
                        lat_wd_d  = OpB;
                        lat_mw_d  = Mem_Write;
                        lat_mr_d  = Mem_Read_In;
                        lat_rw_d  = Reg_Write_In;
                        lat_wb_d  = WBReg_In;
                        vld_d     = 1'b0;
                        mw_d      = 1'b0;
                        mr_d      = 1'b0;
                        rw_d      = 1'b0;
                    end else if (Valid_In) begin
                        pc_d  = PC;
                        res_d = alu_res;
                        wd_d  = OpB;
                        mw_d  = Mem_Write;
                        mr_d  = Mem_Read_In;
                        rw_d  = Reg_Write_In;
                        wb_d  = WBReg_In;
                        vld_d = 1'b1;
                    end else begin
                        vld_d = 1'b0;
                        mw_d  = 1'b0;
                        mr_d  = 1'b0;
                        rw_d  = 1'b0;
                    end
                end
                EX_MUL: begin
                    if (mul_done) begin
                        state_d = EX_IDLE;
                        pc_d    = lat_pc_q;
                        res_d   = mul_product;
                        wd_d    = lat_wd_q;
                        mw_d    = lat_mw_q;
                        mr_d    = lat_mr_q;
                        rw_d    = lat_rw_q;
                        wb_d    = lat_wb_q;
                        vld_d   = 1'b1;
                    end else begin
                        vld_d = 1'b0;
                        mw_d  = 1'b0;
                        mr_d  = 1'b0;
                        rw_d  = 1'b0;
                    end
                end
                default: state_d = EX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EX_IDLE;
            pc_q     <= '0;
            res_q    <= '0;
            wd_q     <= '0;
            mw_q     <= 1'b0;
            mr_q     <= 1'b0;
            rw_q     <= 1'b0;
            wb_q     <= '0;
            vld_q    <= 1'b0;
            lat_pc_q <= '0;
            lat_wd_q <= '0;
            lat_mw_q <= 1'b0;
            lat_mr_q <= 1'b0;
            lat_rw_q <= 1'b0;
            lat_wb_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            res_q    <= res_d;
            wd_q     <= wd_d;
            mw_q     <= mw_d;
            mr_q     <= mr_d;
            rw_q     <= rw_d;
            wb_q     <= wb_d;
            vld_q    <= vld_d;
            lat_pc_q <= lat_pc_d;
            lat_wd_q <= lat_wd_d;
            lat_mw_q <= lat_mw_d;
            lat_mr_q <= lat_mr_d;
            lat_rw_q <= lat_rw_d;
            lat_wb_q <= lat_wb_d;
        end
    end

    always_comb begin
        PCOut         = pc_q;
        ALURes        = res_q;
        WriteDataOut  = wd_q;
        Mem_Write_Out = mw_q;
        Mem_Read_Out  = mr_q;
        Reg_Write_Out = rw_q;
        WBReg_Out     = wb_q;
        Valid_Out     = vld_q;
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: table of single-cycle ops plus multiply, flush and reset sequences.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        Valid_In;
    logic        flush;
    logic [12:0] PC;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic [31:0] Imm;
    logic        ALUSrc;
    logic [3:0]  ALUOp;
    logic        Mem_Write;
    logic        Mem_Read_In;
    logic        Reg_Write_In;
    logic [2:0]  WBReg_In;
    logic        Stall;
    logic [12:0] PCOut;
    logic [31:0] ALURes;
    logic [31:0] WriteDataOut;
    logic        Mem_Write_Out;
    logic        Mem_Read_Out;
    logic        Reg_Write_Out;
    logic [2:0]  WBReg_Out;
    logic        Valid_Out;

    int n_cmp  = 0;
    int n_fail = 0;

    execute_stage dut (
        .clk          (clk),
        .rst          (rst),
        .Valid_In     (Valid_In),
        .flush        (flush),
        .PC           (PC),
        .OpA          (OpA),
        .OpB          (OpB),
        .Imm          (Imm),
        .ALUSrc       (ALUSrc),
        .ALUOp        (ALUOp),
        .Mem_Write    (Mem_Write),
        .Mem_Read_In  (Mem_Read_In),
        .Reg_Write_In (Reg_Write_In),
        .WBReg_In     (WBReg_In),
        .Stall        (Stall),
        .PCOut        (PCOut),
        .ALURes       (ALURes),
        .WriteDataOut (WriteDataOut),
        .Mem_Write_Out(Mem_Write_Out),
        .Mem_Read_Out (Mem_Read_Out),
        .Reg_Write_Out(Reg_Write_Out),
        .WBReg_Out    (WBReg_Out),
        .Valid_Out    (Valid_Out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [12:0] pc;
        logic        mw;
        logic        mr;
        logic        rw;
        logic [2:0]  wb;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic src,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [12:0] pc, input logic mw, input logic mr, input logic rw,
                         input logic [2:0] wb);
        Valid_In     = v;
        ALUOp        = op;
        ALUSrc       = src;
        OpA          = a;
        OpB          = b;
        Imm          = imm;
        PC           = pc;
        Mem_Write    = mw;
        Mem_Read_In  = mr;
        Reg_Write_In = rw;
        WBReg_In     = wb;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".Valid_Out"}, 32'(Valid_Out), 32'd0);
        check({tag, ".Stall"}, 32'(Stall), 32'd0);
        check({tag, ".ALURes"}, ALURes, 32'd0);
        check({tag, ".PCOut"}, 32'(PCOut), 32'd0);
        check({tag, ".WriteDataOut"}, WriteDataOut, 32'd0);
        check({tag, ".ctrl"}, {29'd0, Mem_Write_Out, Mem_Read_Out, Reg_Write_Out}, 32'd0);
        check({tag, ".WBReg_Out"}, 32'(WBReg_Out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int stall_cnt;
        int bad_bubbles;
        int ghost;

        vecs[0]  = '{4'd0, 1'b1, 32'd5,        32'h0,        32'hFFFFFFFD, 13'h001, 1'b0, 1'b0, 1'b1, 3'd1, 32'd2};
        vecs[1]  = '{4'd1, 1'b0, 32'd0,        32'd1,        32'h0,        13'h002, 1'b0, 1'b0, 1'b1, 3'd2, 32'hFFFFFFFF};
        vecs[2]  = '{4'd7, 1'b0, 32'h80000000, 32'd4,        32'h0,        13'h003, 1'b0, 1'b0, 1'b1, 3'd3, 32'hF8000000};
        vecs[3]  = '{4'd8, 1'b0, 32'hFFFFFFFF, 32'd1,        32'h0,        13'h004, 1'b0, 1'b0, 1'b1, 3'd4, 32'd1};
        vecs[4]  = '{4'd8, 1'b0, 32'd1,        32'hFFFFFFFF, 32'h0,        13'h005, 1'b0, 1'b0, 1'b1, 3'd5, 32'd0};
        vecs[5]  = '{4'd2, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        13'h006, 1'b0, 1'b0, 1'b1, 3'd6, 32'h00F000F0};
        vecs[6]  = '{4'd3, 1'b1, 32'h00000F00, 32'h0,        32'h000000F0, 13'h007, 1'b0, 1'b0, 1'b1, 3'd7, 32'h00000FF0};
        vecs[7]  = '{4'd4, 1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0,        13'h008, 1'b0, 1'b0, 1'b1, 3'd0, 32'hF0F00F0F};
        vecs[8]  = '{4'd5, 1'b0, 32'd1,        32'h00000023, 32'h0,        13'h009, 1'b0, 1'b0, 1'b1, 3'd1, 32'd8};
        vecs[9]  = '{4'd6, 1'b0, 32'h80000000, 32'd4,        32'h0,        13'h00A, 1'b0, 1'b0, 1'b1, 3'd2, 32'h08000000};
        vecs[10] = '{4'd0, 1'b1, 32'h100,      32'hDEADBEEF, 32'd4,        13'h0A0, 1'b1, 1'b0, 1'b0, 3'd3, 32'h104};
        vecs[11] = '{4'd0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'h0,        13'h0B0, 1'b0, 1'b1, 1'b1, 3'd4, 32'd0};
        vecs[12] = '{4'd5, 1'b0, 32'd3,        32'd31,       32'h0,        13'h0C0, 1'b0, 1'b0, 1'b1, 3'd6, 32'h80000000};
        vecs[13] = '{4'd12, 1'b0, 32'h1234,    32'h5678,     32'h0,        13'h1FF, 1'b1, 1'b1, 1'b1, 3'd5, 32'd0};

        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 13'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();
        tick();
        check_zero_outputs("idle");

        for (int i = 0; i < 14; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].src, vecs[i].a, vecs[i].b, vecs[i].imm,
                  vecs[i].pc, vecs[i].mw, vecs[i].mr, vecs[i].rw, vecs[i].wb);
            tick();
            check($sformatf("v%0d.ALURes", i), ALURes, vecs[i].res);
            check($sformatf("v%0d.Valid_Out", i), 32'(Valid_Out), 32'd1);
            check($sformatf("v%0d.PCOut", i), 32'(PCOut), 32'(vecs[i].pc));
            check($sformatf("v%0d.WriteDataOut", i), WriteDataOut, vecs[i].b);
            check($sformatf("v%0d.ctrl", i), {29'd0, Mem_Write_Out, Mem_Read_Out, Reg_Write_Out},
                  {29'd0, vecs[i].mw, vecs[i].mr, vecs[i].rw});
            check($sformatf("v%0d.WBReg_Out", i), 32'(WBReg_Out), 32'(vecs[i].wb));
            check($sformatf("v%0d.Stall", i), 32'(Stall), 32'd0);
        end

        // bubble: controls clear, data holds the last values
        drive(1'b0, 4'd0, 1'b0, 32'd77, 32'd88, 32'd0, 13'h055, 1'b1, 1'b1, 1'b1, 3'd7);
        tick();
        check("bubble.Valid_Out", 32'(Valid_Out), 32'd0);
        check("bubble.ctrl", {29'd0, Mem_Write_Out, Mem_Read_Out, Reg_Write_Out}, 32'd0);
        check("bubble.PCOut", 32'(PCOut), 32'h1FF);
        check("bubble.WriteDataOut", WriteDataOut, 32'h5678);

        // MUL 7 x 6 followed by ADD 1 + 1 held by decode during the stall
        drive(1'b1, 4'd9, 1'b0, 32'd7, 32'd6, 32'd0, 13'h010, 1'b0, 1'b0, 1'b1, 3'd2);
        tick();
        drive(1'b1, 4'd0, 1'b0, 32'd1, 32'd1, 32'd0, 13'h011, 1'b0, 1'b0, 1'b1, 3'd3);
        stall_cnt   = 0;
        bad_bubbles = 0;
        while (Stall && stall_cnt < 40) begin
            if (Valid_Out !== 1'b0 || Reg_Write_Out !== 1'b0) bad_bubbles++;
            tick();
            stall_cnt++;
        end
        check("mul7x6.stall_cycles", 32'(stall_cnt), 32'd32);
        check("mul7x6.bubbles", 32'(bad_bubbles), 32'd0);
        check("mul7x6.ALURes", ALURes, 32'd42);
        check("mul7x6.Valid_Out", 32'(Valid_Out), 32'd1);
        check("mul7x6.PCOut", 32'(PCOut), 32'h010);
        check("mul7x6.WBReg_Out", 32'(WBReg_Out), 32'd2);
        check("mul7x6.WriteDataOut", WriteDataOut, 32'd6);
        check("mul7x6.Reg_Write_Out", 32'(Reg_Write_Out), 32'd1);
        tick();
        check("add_after_mul.ALURes", ALURes, 32'd2);
        check("add_after_mul.Valid_Out", 32'(Valid_Out), 32'd1);
        check("add_after_mul.PCOut", 32'(PCOut), 32'h011);

        // MUL wrap: 0xFFFFFFFF x 2 using the immediate as multiplier
        drive(1'b1, 4'd9, 1'b1, 32'hFFFFFFFF, 32'd0, 32'd2, 13'h020, 1'b0, 1'b0, 1'b1, 3'd4);
        tick();
        drive(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 13'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        stall_cnt = 0;
        while (Stall && stall_cnt < 40) begin
            tick();
            stall_cnt++;
        end
        check("mulwrap.stall_cycles", 32'(stall_cnt), 32'd32);
        check("mulwrap.ALURes", ALURes, 32'hFFFFFFFE);
        check("mulwrap.Valid_Out", 32'(Valid_Out), 32'd1);

        // flush at iteration 10 of MUL 3 x 5
        drive(1'b1, 4'd9, 1'b0, 32'd3, 32'd5, 32'd0, 13'h030, 1'b0, 1'b0, 1'b1, 3'd5);
        tick();
        drive(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 13'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 10; k++) tick();
        check("preflush.Stall", 32'(Stall), 32'd1);
        flush = 1'b1;
        drive(1'b1, 4'd0, 1'b0, 32'd100, 32'd100, 32'd0, 13'h0EE, 1'b0, 1'b0, 1'b1, 3'd6);
        tick();
        flush = 1'b0;
        check("flush.Valid_Out", 32'(Valid_Out), 32'd0);
        check("flush.Stall", 32'(Stall), 32'd0);
        check("flush.Reg_Write_Out", 32'(Reg_Write_Out), 32'd0);
        drive(1'b1, 4'd0, 1'b0, 32'd10, 32'd20, 32'd0, 13'h031, 1'b0, 1'b0, 1'b1, 3'd1);
        tick();
        check("postflush_add.ALURes", ALURes, 32'd30);
        check("postflush_add.Valid_Out", 32'(Valid_Out), 32'd1);
        drive(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 13'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        ghost = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (Valid_Out !== 1'b0 || Stall !== 1'b0) ghost++;
        end
        check("flush.no_mul_result", 32'(ghost), 32'd0);
        check("flush.ALURes_held", ALURes, 32'd30);

        // asynchronous reset in the middle of a multiply
        drive(1'b1, 4'd9, 1'b0, 32'd9, 32'd9, 32'd0, 13'h040, 1'b0, 1'b0, 1'b1, 3'd7);
        tick();
        drive(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 13'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 5; k++) tick();
        check("prereset.Stall", 32'(Stall), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("midreset");
        tick();
        rst = 1'b0;
        stall_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (Valid_Out !== 1'b0 || Stall !== 1'b0) stall_cnt++;
        end
        check("postreset.quiet", 32'(stall_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
